// File: rtl/icache_pkg.sv
// icache_pkg: shared types and geometry for the direct-mapped instruction cache
package icache_pkg;
  localparam int ADDR_W      = 30;
  localparam int BLK_ADDR_W  = 28;
  localparam int LINE_W      = 128;
  localparam int WORD_W      = 32;
  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_WORDS = 4;
  localparam int INDEX_W     = $clog2(NUM_BLOCKS);
  localparam int OFFSET_W    = $clog2(BLOCK_WORDS);
  localparam int TAG_W       = ADDR_W - OFFSET_W - INDEX_W;
  typedef enum logic {COMPARE, ALLOCATE} state_t;
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } line_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and refill-side signals of the instruction cache
//   slave  : the cache (takes fetch requests, issues refills)
//   master : the environment (IF stage plus instruction memory)
interface icache_if;
  import icache_pkg::*;
  logic                  proc_read;
  logic [ADDR_W-1:0]     proc_addr;
  logic [WORD_W-1:0]     proc_rdata;
  logic                  proc_stall;
  logic                  mem_read;
  logic [BLK_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ready;
  modport slave (
    input  proc_read, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );
  modport master (
    output proc_read, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );
endinterface

// File: rtl/icache_word_sel.sv
// icache_word_sel: picks one 32-bit word out of a 128-bit line by word offset
//   line   : cache line, word 0 in bits [31:0]
//   offset : word offset within the line
//   word   : selected word
module icache_word_sel
  import icache_pkg::*;
(
  input  logic [LINE_W-1:0]   line,
  input  logic [OFFSET_W-1:0] offset,
  output logic [WORD_W-1:0]   word
);
  assign word = line[offset*WORD_W +: WORD_W];
endmodule

// File: rtl/icache_rsp.sv
// icache_rsp: read-only direct-mapped instruction cache with blocking line refill
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : fetch request/response (proc_*) and refill request/response (mem_*)
module icache_rsp
  import icache_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  icache_if.slave   bus
);
  state_t                state, next_state;
  line_t                 lines [NUM_BLOCKS];
  logic [INDEX_W-1:0]    idx, fill_idx;
  logic [TAG_W-1:0]      tag;
  logic [WORD_W-1:0]     word;
  logic                  hit, miss, fill;
  logic                  mem_read_q;
  logic [BLK_ADDR_W-1:0] mem_addr_q;
  assign idx      = bus.proc_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign tag      = bus.proc_addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign fill_idx = mem_addr_q[INDEX_W-1:0];
  assign hit      = bus.proc_read & lines[idx].valid & (lines[idx].tag == tag);
  assign miss     = (state == COMPARE) & bus.proc_read & ~hit;
  assign fill     = (state == ALLOCATE) & bus.mem_ready;
  assign bus.mem_read = mem_read_q;
  assign bus.mem_addr = mem_addr_q;
  icache_word_sel u_word_sel (
    .line   (lines[idx].data),
    .offset (bus.proc_addr[OFFSET_W-1:0]),
    .word   (word)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COMPARE;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state      <= next_state;
      mem_read_q <= (next_state == ALLOCATE);
      if (miss) mem_addr_q <= bus.proc_addr[ADDR_W-1:OFFSET_W];
    end
  end
  // Outputs are forced low while reset is held so the fetch side sees an idle cache.
  always_comb begin
    next_state     = miss ? ALLOCATE : fill ? COMPARE : state;
    bus.proc_stall = rst_n & ((state == ALLOCATE) | miss);
    bus.proc_rdata = (rst_n & (state == COMPARE) & hit) ? word : '0;
  end
  // Only valid bits are reset; tag and data are qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) lines[i].valid <= 1'b0;
    end else if (fill) begin
      lines[fill_idx] <= '{valid: 1'b1, tag: mem_addr_q[BLK_ADDR_W-1:INDEX_W], data: bus.mem_rdata};
    end
  end
endmodule

// File: tb/tb_icache_rsp.sv
// tb_icache_rsp: directed stimulus with a per-cycle behavioural cache model and literal spot checks
module tb_icache_rsp;
  import icache_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  icache_if bus();
  icache_rsp dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] wd(input int b, input int k);
    return 32'((b << 8) | (k * 'h11));
  endfunction
  function automatic logic [127:0] blk(input int b);
    return {wd(b, 3), wd(b, 2), wd(b, 1), wd(b, 0)};
  endfunction
  logic         m_valid [NUM_BLOCKS];
  logic [27:0]  m_blk   [NUM_BLOCKS];
  logic [127:0] m_data  [NUM_BLOCKS];
  logic         m_busy;
  logic [27:0]  m_addr;
  function automatic int slot(input logic [27:0] b);
    return int'(b % NUM_BLOCKS);
  endfunction
  function automatic logic present(input logic [29:0] a);
    return m_valid[slot(a[29:2])] && m_blk[slot(a[29:2])] == a[29:2];
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) m_valid[i] <= 1'b0;
      m_busy <= 1'b0;
      m_addr <= '0;
    end else if (m_busy) begin
      if (bus.mem_ready) begin
        m_valid[slot(m_addr)] <= 1'b1;
        m_blk[slot(m_addr)]   <= m_addr;
        m_data[slot(m_addr)]  <= bus.mem_rdata;
        m_busy                <= 1'b0;
      end
    end else if (bus.proc_read && !present(bus.proc_addr)) begin
      m_busy <= 1'b1;
      m_addr <= bus.proc_addr[29:2];
    end
  end
  always @(negedge clk) begin
    logic [29:0] a;
    logic h;
    a = bus.proc_addr;
    if (!rst_n) begin
      chk("cmp stall", bus.proc_stall, 0);
      chk("cmp rdata", bus.proc_rdata, 0);
      chk("cmp mem_read", bus.mem_read, 0);
      chk("cmp mem_addr", bus.mem_addr, 0);
    end else begin
      h = !m_busy && bus.proc_read && present(a);
      chk("cmp stall", bus.proc_stall, m_busy || (bus.proc_read && !present(a)));
      chk("cmp rdata", bus.proc_rdata, h ? m_data[slot(a[29:2])][a[1:0]*32 +: 32] : 32'h0);
      chk("cmp mem_read", bus.mem_read, m_busy);
      chk("cmp mem_addr", bus.mem_addr, m_addr);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic access(input logic [29:0] a);
    cyc();
    bus.proc_read = 1'b1;
    bus.proc_addr = a;
    #2;
  endtask
  task automatic fill(input int b, input int lat);
    repeat (lat + 1) begin
      cyc();
      #2;
      chk("fill mem_read", bus.mem_read, 1);
      chk("fill mem_addr", bus.mem_addr, b);
      chk("fill stall", bus.proc_stall, 1);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = blk(b);
    cyc();
    bus.mem_ready = 1'b0;
    #2;
  endtask
  initial begin
    bus.proc_read = 1'b0;
    bus.proc_addr = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("reset stall", bus.proc_stall, 0);
    chk("reset mem_read", bus.mem_read, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset rdata", bus.proc_rdata, 0);
    access(30'h0);
    chk("first miss stall", bus.proc_stall, 1);
    fill(0, 3);
    chk("first fill stall", bus.proc_stall, 0);
    chk("first fill rdata", bus.proc_rdata, 32'h0);
    for (int k = 1; k < 4; k++) begin
      access(30'(k));
      chk("seq stall", bus.proc_stall, 0);
      chk("seq rdata", bus.proc_rdata, 32'h11 * k);
      chk("seq mem_read", bus.mem_read, 0);
    end
    access(30'h20);
    chk("conflict stall", bus.proc_stall, 1);
    fill(8, 2);
    chk("conflict rdata", bus.proc_rdata, 32'h800);
    access(30'h0);
    chk("thrash stall", bus.proc_stall, 1);
    fill(0, 1);
    chk("thrash rdata", bus.proc_rdata, 32'h0);
    access(30'h7);
    fill(1, 20);
    chk("hold rdata", bus.proc_rdata, 32'h133);
    cyc();
    bus.proc_read = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {4{32'hdeadbeef}};
    cyc();
    bus.mem_ready = 1'b0;
    access(30'h1);
    chk("spurious hit stall", bus.proc_stall, 0);
    chk("spurious hit rdata", bus.proc_rdata, 32'h11);
    access(30'h6);
    chk("spurious hit2 rdata", bus.proc_rdata, 32'h122);
    access(30'h9);
    chk("move miss stall", bus.proc_stall, 1);
    cyc();
    #2;
    chk("move mem_addr", bus.mem_addr, 2);
    bus.proc_addr = 30'hD;
    fill(2, 0);
    chk("move relookup stall", bus.proc_stall, 1);
    chk("move relookup mem_read", bus.mem_read, 0);
    fill(3, 1);
    chk("move second rdata", bus.proc_rdata, 32'h311);
    access(30'h9);
    chk("move first rdata", bus.proc_rdata, 32'h211);
    cyc();
    bus.proc_read = 1'b0;
    repeat (10) begin
      cyc();
      #2;
      chk("idle stall", bus.proc_stall, 0);
      chk("idle mem_read", bus.mem_read, 0);
    end
    access(30'h100);
    chk("abort miss stall", bus.proc_stall, 1);
    cyc();
    #2;
    chk("abort mem_read", bus.mem_read, 1);
    chk("abort mem_addr", bus.mem_addr, 32'h40);
    rst_n = 1'b0;
    bus.proc_read = 1'b0;
    #1;
    chk("async reset mem_read", bus.mem_read, 0);
    chk("async reset stall", bus.proc_stall, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = blk(32'h40);
    cyc();
    bus.mem_ready = 1'b0;
    #2;
    chk("late ready mem_read", bus.mem_read, 0);
    access(30'h1);
    chk("post reset miss stall", bus.proc_stall, 1);
    chk("post reset mem_read", bus.mem_read, 0);
    fill(0, 2);
    chk("post reset rdata", bus.proc_rdata, 32'h11);
    cyc();
    bus.proc_read = 1'b0;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_rsp.md
Name: icache_rsp

Overview:
Read-only, direct-mapped instruction cache.
- Answers the fetch addresses produced by the CPU's next-PC logic.
- Returns the 32-bit instruction on the processor side.
- Refills missing blocks from instruction memory over a 128-bit request/ready interface.
- Sits between the IF stage and instruction memory; stalls the pipeline on a miss.

Parameters:
NUM_BLOCKS, 8, number of cache lines (power of 2); INDEX_W = log2(NUM_BLOCKS)
BLOCK_WORDS, 4, 32-bit words per line; fixed at 4 to match mem_rdata width
TAG_W, 25, equals 30 - 2 - INDEX_W; derived, must not be overridden independently

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
proc_read  input  1  fetch request valid
proc_addr  input  30  word address (byte PC[31:2])
proc_rdata  output  32  instruction for proc_addr; valid when proc_read=1 and proc_stall=0
proc_stall  output  1  1 = instruction not yet available, IF must hold PC
mem_read  output  1  block refill request
mem_addr  output  28  block address (word address[29:2])
mem_rdata  input  128  refill block; word 0 in bits [31:0]
mem_ready  input  1  one-cycle pulse: mem_rdata valid for the request in flight

Behaviour:
- Interface clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Address split:
  - offset = proc_addr[1:0]
  - index = proc_addr[INDEX_W+1:2]
  - tag = proc_addr[29:INDEX_W+2]
- Storage per line: valid bit, tag, 128-bit data.
- Reset (rst_n=0, any state):
  - all valid bits cleared; state = COMPARE
  - mem_read=0, mem_addr=0, proc_stall=0, proc_rdata=0
  - tag and data arrays need no reset
- States: COMPARE, ALLOCATE.
- COMPARE:
  - hit = proc_read & valid[index] & (tag_arr[index]==tag).
  - On a hit: proc_rdata = data_arr[index] word[offset] combinationally, proc_stall=0, zero added latency.
  - On a miss (proc_read & ~hit): proc_stall=1 combinationally in the same cycle.
    - Latch miss_addr = proc_addr[29:2].
    - Next state ALLOCATE.
  - proc_read=0: proc_stall=0, proc_rdata don't-care (drive 0), no state change.
- ALLOCATE:
  - mem_read=1 and mem_addr=miss_addr, both registered and stable until mem_ready.
  - proc_stall=1.
  - On mem_ready=1:
    - write mem_rdata into data_arr[miss index]
    - set tag and valid
    - deassert mem_read next cycle
    - return to COMPARE
  - The re-lookup in COMPARE hits the following cycle. Miss penalty = memory latency + 2 cycles.
- mem_ready while not in ALLOCATE: ignored.
- mem_ready in the same cycle mem_read rises: accepted; the request is registered the cycle before.
- proc_addr changing while stalled: ignored. The fill uses the latched miss_addr; the re-lookup uses the current proc_addr and may miss again (legal, re-enter ALLOCATE).
- Fill replaces any valid line at that index unconditionally. Read-only, so no writeback.
- Reset mid-ALLOCATE: request abandoned. A late mem_ready after reset release is ignored because the state is COMPARE.
- Index collision: two tags with the same index thrash. Each access misses; no deadlock.

Decomposition:
- Shared package icache_pkg:
  - state enum (COMPARE, ALLOCATE)
  - constants ADDR_W=30, BLK_ADDR_W=28, LINE_W=128, WORD_W=32
  - line struct {valid, tag, data}
- One natural sub-module: icache_word_sel, a 128-to-32 mux by offset. All other logic stays in icache_rsp.

Test Plan:
- Reset, then proc_read=1, proc_addr=0x0000000 -> proc_stall=1 same cycle. Next cycle mem_read=1, mem_addr=0x0000000. Drive mem_ready with mem_rdata={0x33,0x22,0x11,0x00} and 3-cycle memory latency -> proc_stall=0 at cycle 5, proc_rdata=0x00000000 (word0 = 0x00).
- After that fill, addresses 0x0000001/2/3 back-to-back -> stall=0 each cycle, rdata 0x11, 0x22, 0x33; mem_read stays 0.
- Conflict: fill 0x0000000, then 0x0000020 (same index 0, different tag) -> miss with mem_addr=0x0000008. Then 0x0000000 again -> misses again with mem_addr=0x0000000.
- Stall hold: hold mem_ready=0 for 20 cycles -> mem_read=1 and mem_addr stable, proc_stall=1 throughout. A spurious mem_ready in COMPARE with proc_read=0 -> no array change; a subsequent access to a previously filled address still hits.
- Reset mid-ALLOCATE: assert rst_n=0 while mem_read=1 -> mem_read=0 immediately (async). A later mem_ready pulse is ignored. Prior hit address 0x0000001 now misses (valid cleared).
- proc_read=0 idle for 10 cycles -> proc_stall=0, mem_read=0, no state change.
